// File: rtl/pp_pipeline_accel_mul_rnd_sat.sv
// Pipelined signed/unsigned multiply(-accumulate) with round-half-up scaling and saturation.
// Latency NUM_STAGE ce-enabled cycles, one sample per ce cycle, no back-pressure (ce=0 stalls everything).
module pp_pipeline_accel_mul_rnd_sat #(
  parameter int A_W       = 11,
  parameter int B_W       = 22,
  parameter int A_SIGNED  = 0,
  parameter int B_SIGNED  = 1,
  parameter int OUT_W     = 22,
  parameter int SHIFT     = 0,
  parameter int ROUND     = 1,
  parameter int SATURATE  = 1,
  parameter int ACC_EN    = 0,
  parameter int ACC_W     = 48,
  parameter int NUM_STAGE = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce,
  input  logic             in_valid,
  input  logic [A_W-1:0]   din0,
  input  logic [B_W-1:0]   din1,
  input  logic             acc_clr,
  output logic             out_valid,
  output logic [OUT_W-1:0] dout,
  output logic             sat_flag
);

  localparam int P_W     = A_W + B_W + 1;
  localparam bit OS      = (A_SIGNED != 0) || (B_SIGNED != 0);
  localparam int S_W     = (ACC_EN != 0) ? ACC_W : P_W;
  localparam int C_W     = (S_W + 1 > OUT_W + 2) ? S_W + 1 : OUT_W + 2;
  localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic signed [S_W:0]   ONE_S = 1;
  localparam logic signed [S_W:0]   RND   = (SHIFT > 0 && ROUND != 0) ? (ONE_S <<< RND_POS) : '0;
  localparam logic signed [C_W-1:0] ONE_C = 1;
  localparam logic signed [C_W-1:0] MAXV  = OS ? (ONE_C <<< (OUT_W - 1)) - ONE_C : (ONE_C <<< OUT_W) - ONE_C;
  localparam logic signed [C_W-1:0] MINV  = OS ? -(ONE_C <<< (OUT_W - 1)) : '0;

  if (NUM_STAGE < 4) begin : g_bad_stage
    $fatal(1, "NUM_STAGE must be at least 4");
  end
  if (SHIFT >= A_W + B_W) begin : g_bad_shift
    $fatal(1, "SHIFT must be below A_W+B_W");
  end
  if (ACC_EN != 0 && ACC_W < A_W + B_W + 1) begin : g_bad_acc
    $fatal(1, "ACC_W too narrow for the product");
  end

  typedef struct packed {
    logic             vld;
    logic             sat;
    logic [OUT_W-1:0] dat;
  } stage_t;

  logic [A_W-1:0]         a_q;
  logic [B_W-1:0]         b_q;
  logic                   v1, clr1, v2, clr2, v3;
  logic signed [P_W-1:0]  a_ext, b_ext, prod_q;
  logic signed [S_W-1:0]  s_nxt, s_q;
  logic signed [S_W:0]    rsum, rsh;
  logic signed [C_W-1:0]  shx;
  logic                   over, under;
  stage_t                 st4, arrive;

  assign a_ext = {{(P_W - A_W){(A_SIGNED != 0) && a_q[A_W-1]}}, a_q};
  assign b_ext = {{(P_W - B_W){(B_SIGNED != 0) && b_q[B_W-1]}}, b_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q    <= '0;
      b_q    <= '0;
      v1     <= 1'b0;
      clr1   <= 1'b0;
      prod_q <= '0;
      v2     <= 1'b0;
      clr2   <= 1'b0;
      s_q    <= '0;
      v3     <= 1'b0;
    end else if (ce) begin
      a_q    <= din0;
      b_q    <= din1;
      v1     <= in_valid;
      clr1   <= acc_clr;
      prod_q <= a_ext * b_ext;
      v2     <= v1;
      clr2   <= clr1;
      s_q    <= s_nxt;
      v3     <= v2;
    end
  end

  if (ACC_EN != 0) begin : g_acc
    logic signed [ACC_W-1:0] acc_q, prod_x, acc_nxt;
    assign prod_x  = ACC_W'(prod_q);
    assign acc_nxt = (clr2 ? '0 : acc_q) + prod_x;
    assign s_nxt   = acc_nxt;
    // Bubbles must not disturb the running sum.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
        acc_q <= '0;
      else if (ce && v2)
        acc_q <= acc_nxt;
    end
  end else begin : g_mul
    logic unused_clr;
    assign unused_clr = clr2;
    assign s_nxt      = prod_q;
  end

  // One extra bit on the rounding add so the half-LSB bias never overflows.
  always_comb begin
    rsum    = {s_q[S_W-1], s_q} + RND;
    rsh     = rsum >>> SHIFT;
    shx     = C_W'(rsh);
    over    = shx > MAXV;
    under   = shx < MINV;
    st4.vld = v3;
    st4.sat = over || under;
    if (SATURATE != 0 && over)
      st4.dat = MAXV[OUT_W-1:0];
    else if (SATURATE != 0 && under)
      st4.dat = MINV[OUT_W-1:0];
    else
      st4.dat = shx[OUT_W-1:0];
  end

  if (NUM_STAGE > 4) begin : g_dly
    stage_t dly [NUM_STAGE-4];
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < NUM_STAGE - 4; i++)
          dly[i] <= '0;
      end else if (ce) begin
        dly[0] <= st4;
        for (int i = 1; i < NUM_STAGE - 4; i++)
          dly[i] <= dly[i-1];
      end
    end
    assign arrive = dly[NUM_STAGE-5];
  end else begin : g_nodly
    assign arrive = st4;
  end

  // Result and flag hold across bubbles; only out_valid drops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      dout      <= '0;
      sat_flag  <= 1'b0;
    end else if (ce) begin
      out_valid <= arrive.vld;
      if (arrive.vld) begin
        dout     <= arrive.dat;
        sat_flag <= arrive.sat;
      end
    end
  end

endmodule

// File: tb/tb_pp_pipeline_accel_mul_rnd_sat.sv
// Directed bench: five configurations share one stimulus bus; expected values are hand-computed.
module tb_pp_pipeline_accel_mul_rnd_sat;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce = 1'b1;
  logic        in_valid = 1'b0;
  logic        acc_clr = 1'b0;
  logic [10:0] din0 = '0;
  logic [21:0] din1 = '0;
  logic [4:0]  ov, sf;
  logic [21:0] dv [5];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  // 0: default  1: wrap  2: shift4 round  3: shift4 floor  4: accumulate
  pp_pipeline_accel_mul_rnd_sat u_def (.clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid),
    .din0(din0), .din1(din1), .acc_clr(acc_clr), .out_valid(ov[0]), .dout(dv[0]), .sat_flag(sf[0]));
  pp_pipeline_accel_mul_rnd_sat #(.SATURATE(0)) u_wrap (.clk(clk), .reset_n(reset_n), .ce(ce),
    .in_valid(in_valid), .din0(din0), .din1(din1), .acc_clr(acc_clr), .out_valid(ov[1]), .dout(dv[1]),
    .sat_flag(sf[1]));
  pp_pipeline_accel_mul_rnd_sat #(.SHIFT(4), .ROUND(1)) u_rnd (.clk(clk), .reset_n(reset_n), .ce(ce),
    .in_valid(in_valid), .din0(din0), .din1(din1), .acc_clr(acc_clr), .out_valid(ov[2]), .dout(dv[2]),
    .sat_flag(sf[2]));
  pp_pipeline_accel_mul_rnd_sat #(.SHIFT(4), .ROUND(0)) u_flr (.clk(clk), .reset_n(reset_n), .ce(ce),
    .in_valid(in_valid), .din0(din0), .din1(din1), .acc_clr(acc_clr), .out_valid(ov[3]), .dout(dv[3]),
    .sat_flag(sf[3]));
  pp_pipeline_accel_mul_rnd_sat #(.ACC_EN(1)) u_acc (.clk(clk), .reset_n(reset_n), .ce(ce),
    .in_valid(in_valid), .din0(din0), .din1(din1), .acc_clr(acc_clr), .out_valid(ov[4]), .dout(dv[4]),
    .sat_flag(sf[4]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [10:0] a, input logic [21:0] b, input logic v, input logic c);
    din0     = a;
    din1     = b;
    in_valid = v;
    acc_clr  = c;
  endtask

  // One sample, then idle until its result has reached the output register.
  task automatic one(input logic [10:0] a, input logic [21:0] b, input logic c);
    drive(a, b, 1'b1, c);
    step();
    drive('0, '0, 1'b0, 1'b0);
    repeat (3) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] va [5];
    logic [21:0] vb [5];
    logic        vv [5];
    logic        vc [5];
    logic [31:0] ae [4];
    int          lat, k, sent, ce_edges, ghost;
    logic        pv;
    logic [21:0] pd;

    step();
    step();
    chk("rst_vld", 32'(ov), 32'd0);
    chk("rst_sat", 32'(sf), 32'd0);
    chk("rst_dout_def", 32'(dv[0]), 32'd0);
    chk("rst_dout_acc", 32'(dv[4]), 32'd0);
    reset_n = 1'b1;
    step();

    // Latency and basic signed product
    lat = 0;
    drive(11'd2047, 22'h3FFFFD, 1'b1, 1'b0);
    for (int n = 1; n <= 10; n++) begin
      step();
      drive('0, '0, 1'b0, 1'b0);
      if (ov[0]) begin
        lat = n;
        break;
      end
    end
    chk("latency", 32'(lat), 32'd4);
    chk("neg_dout", 32'(dv[0]), 32'h3FE803);
    chk("neg_sat", 32'(sf[0]), 32'd0);
    step();
    chk("vld_pulse", 32'(ov[0]), 32'd0);
    chk("hold_dout", 32'(dv[0]), 32'h3FE803);

    // Positive and negative overflow, saturating and wrapping
    one(11'd2047, 22'h1FFFFF, 1'b0);
    chk("pos_vld", 32'(ov[0]), 32'd1);
    chk("pos_clamp", 32'(dv[0]), 32'h1FFFFF);
    chk("pos_sat", 32'(sf[0]), 32'd1);
    chk("pos_wrap", 32'(dv[1]), 32'h1FF801);
    chk("pos_wrap_sat", 32'(sf[1]), 32'd1);
    one(11'd2047, 22'h200000, 1'b0);
    chk("neg_clamp", 32'(dv[0]), 32'h200000);
    chk("neg_clamp_sat", 32'(sf[0]), 32'd1);
    chk("neg_wrap", 32'(dv[1]), 32'h200000);
    chk("neg_wrap_sat", 32'(sf[1]), 32'd1);

    // Rounding versus floor at SHIFT=4
    one(11'd1, 22'd25, 1'b0);
    chk("rnd_25", 32'(dv[2]), 32'd2);
    chk("flr_25", 32'(dv[3]), 32'd1);
    chk("rnd_25_sat", 32'(sf[2]), 32'd0);
    one(11'd1, 22'h3FFFE7, 1'b0);
    chk("rnd_m25", 32'(dv[2]), 32'h3FFFFE);
    chk("flr_m25", 32'(dv[3]), 32'h3FFFFE);
    one(11'd1, 22'd24, 1'b0);
    chk("rnd_24", 32'(dv[2]), 32'd2);
    one(11'd1, 22'd23, 1'b0);
    chk("rnd_23", 32'(dv[2]), 32'd1);

    // Accumulate with a bubble and a restart
    va = '{11'd10, 11'd0, 11'd10, 11'd10, 11'd2};
    vb = '{22'd5, 22'd0, 22'd5, 22'd5, 22'd3};
    vv = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vc = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    ae = '{32'd50, 32'd100, 32'd150, 32'd6};
    k = 0;
    for (int c = 0; c < 14; c++) begin
      if (c < 5) drive(va[c], vb[c], vv[c], vc[c]);
      else       drive('0, '0, 1'b0, 1'b0);
      step();
      if (ov[4]) begin
        if (k < 4) chk($sformatf("acc_%0d", k), 32'(dv[4]), ae[k]);
        k++;
      end
    end
    chk("acc_count", 32'(k), 32'd4);

    // Stream of 8 with ce pattern 1,0,0 repeating
    sent = 0;
    k = 0;
    ce_edges = 0;
    for (int c = 0; c < 200 && k < 8; c++) begin
      ce = (c % 3 == 0);
      if (sent < 8) drive(11'(sent + 1), 22'd100, 1'b1, 1'b0);
      else          drive('0, '0, 1'b0, 1'b0);
      pv = ov[0];
      pd = dv[0];
      step();
      if (ce) begin
        ce_edges++;
        if (sent < 8) sent++;
        if (ov[0]) begin
          if (k == 0) chk("ce_latency", 32'(ce_edges), 32'd4);
          chk($sformatf("ce_dat_%0d", k), 32'(dv[0]), 32'((k + 1) * 100));
          k++;
        end
      end else begin
        chk("frz_vld", 32'(ov[0]), 32'(pv));
        chk("frz_dout", 32'(dv[0]), 32'(pd));
      end
    end
    ce = 1'b1;
    drive('0, '0, 1'b0, 1'b0);
    chk("ce_count", 32'(k), 32'd8);

    // Asynchronous reset with samples in flight
    for (int i = 0; i < 3; i++) begin
      drive(11'd4, 22'd5, 1'b1, 1'b0);
      step();
    end
    drive('0, '0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #2;
    chk("arst_vld", 32'(ov), 32'd0);
    chk("arst_sat", 32'(sf), 32'd0);
    chk("arst_dout_def", 32'(dv[0]), 32'd0);
    chk("arst_dout_acc", 32'(dv[4]), 32'd0);
    step();
    reset_n = 1'b1;
    ghost = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (ov[4]) ghost++;
    end
    chk("arst_ghost", 32'(ghost), 32'd0);
    one(11'd4, 22'd4, 1'b0);
    chk("post_rst_vld", 32'(ov[4]), 32'd1);
    chk("post_rst_acc", 32'(dv[4]), 32'd16);
    chk("post_rst_def", 32'(dv[0]), 32'd16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
